fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Program-counter and fetch sequencer for the monocycle MIPS core.
- Drives the instruction ROM word address and qualifies the returned word for the decode/control stage.
- Applies jump/branch redirects and pipeline stalls, halts on a sentinel instruction, and traps out-of-range or misaligned targets.
- Sits between the instruction ROM (asynchronous read, word-indexed by address>>2) and the control unit.

Parameters:
MEM_WORDS, 64, ROM depth in 32-bit words; legal PC range is 0 to 4*MEM_WORDS-4.
RESET_PC, 32'h0000_0000, PC value loaded on reset and on restart.
HALT_WORD, 32'h0000_000C, instruction encoding (syscall) that stops fetch.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  pulse: IDLE->RUN, or HALT->RUN with PC reloaded to RESET_PC.
stall  in  1  hold current PC and instruction this cycle.
jump  in  1  redirect to jump_target (priority over branch).
jump_target  in  32  byte address.
branch_taken  in  1  redirect to branch_target.
branch_target  in  32  byte address.
i_addr  out  32  byte address to instruction ROM; equals pc.
i_data  in  32  word returned by ROM (same-cycle, combinational).
instr  out  32  i_data when instr_valid, else 32'h0.
instr_valid  out  1  instruction is live for execution this cycle.
pc  out  32  current PC.
pc_plus4  out  32  pc + 4 (mod 2^32), for link/branch arithmetic.
halted  out  1  state == HALT.
fault  out  1  state == FAULT.
fault_addr  out  32  offending target, latched on fault entry.
retired  out  32  count of instructions advanced past; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=IDLE, pc=RESET_PC, fault_addr=0, retired=0.
  - Hence instr_valid=0, instr=0, halted=0, fault=0.
- States: IDLE, RUN, HALT, FAULT; 2-bit encoding.
- IDLE: pc held; start -> RUN. All other inputs ignored.
- RUN:
  - instr_valid = !stall && i_data != HALT_WORD.
  - Per rising edge, highest priority first:
    1. stall=1: pc, state and retired unchanged; jump/branch ignored that cycle, so the requester must hold them.
    2. i_data==HALT_WORD: -> HALT; pc unchanged; retired unchanged.
    3. Compute next = jump ? jump_target : branch_taken ? branch_target : pc_plus4.
    4. If next[1:0]!=0 or next >= 4*MEM_WORDS: -> FAULT, fault_addr=next, pc unchanged, retired unchanged.
    5. Otherwise pc=next and retired+=1 (saturating).
  - Sequential wrap from the last word (pc_plus4 == 4*MEM_WORDS) is an out-of-range fault, not a wrap to 0.
  - jump and branch_taken both high: jump wins.
- HALT: pc, retired held.
  - start -> RUN with pc=RESET_PC; retired keeps counting, it is not cleared.
  - stall/jump/branch ignored.
- FAULT: sticky; only reset exits. start is ignored.
- instr_valid is never high in IDLE, HALT or FAULT.
- Latency:
  - Redirect takes effect at the PC on the edge it is sampled.
  - The new instruction is visible the same cycle after that edge, since ROM read is combinational.
- Width: all address arithmetic is 32-bit unsigned; comparison against 4*MEM_WORDS is unsigned.

Decomposition:
- Shared package holds:
  - state typedef/localparams ST_IDLE=0, ST_RUN=1, ST_HALT=2, ST_FAULT=3;
  - HALT_WORD default constant;
  - INSTR_BYTES=4.
- One natural sub-module: pc_next_sel, combinational next-PC mux plus range/alignment check.
  - Outputs: next, next_bad.
  - Reusable by a future pipelined fetch.

Test Plan:
1. Reset, then start pulse, ROM holds 4 NOPs then HALT_WORD at 0x10 -> pc steps 0,4,8,C,10; instr_valid for 4 cycles; halted=1 with pc=0x10; retired=4.
2. In RUN at pc=0x08, assert jump=1 (target 0x20) and branch_taken=1 (target 0x30) together -> next pc=0x20; retired increments by 1.
3. stall=1 for 3 cycles at pc=0x0C with branch_taken=1 -> pc stays 0x0C, instr_valid=0, retired unchanged; after stall drops and branch is held one more cycle -> pc=branch_target.
4. Fault cases:
   - branch_target=0x0000_0102 -> FAULT, fault_addr=0x102, pc unchanged.
   - Separately, sequential fetch at pc=0xFC with MEM_WORDS=64 -> FAULT, fault_addr=0x100.
   - start ignored in both cases; reset restores IDLE with pc=0.
5. In HALT, pulse start -> RUN with pc=RESET_PC; retired continues from its prior value.
6. Assert reset asynchronously mid-cycle in RUN at pc=0x14 -> outputs reach reset values before the next clock edge; no further pc change until start.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the fetch controller
// Holds the controller state encoding, the default halt sentinel and the
// instruction size used by all address arithmetic.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // syscall encoding; fetching it stops the sequencer
    localparam logic [31:0] HALT_WORD_DEF = 32'h0000_000C;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller bus: control inputs, ROM port, status outputs
// Ports (master = fetch controller side):
//   start, stall, jump, jump_target, branch_taken, branch_target : sequencing controls in
//   i_addr / i_data                                              : ROM byte address out, word in
//   instr, instr_valid                                           : qualified word to decode
//   pc, pc_plus4, halted, fault, fault_addr, retired             : status out
interface fetch_ctrl_if;

    logic        start;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] retired;

    modport master (
        input  start, stall, jump, jump_target, branch_taken, branch_target, i_data,
        output i_addr, instr, instr_valid, pc, pc_plus4, halted, fault, fault_addr, retired
    );

    modport slave (
        output start, stall, jump, jump_target, branch_taken, branch_target, i_data,
        input  i_addr, instr, instr_valid, pc, pc_plus4, halted, fault, fault_addr, retired
    );

endinterface

// File: rtl/fetch_ctrl_pc_next_sel.sv
// rtl/fetch_ctrl_pc_next_sel.sv - next-PC mux with range and alignment check
// Ports:
//   pc                          : current program counter
//   jump, jump_target           : jump redirect (wins over branch)
//   branch_taken, branch_target : branch redirect
//   pc_plus4                    : sequential successor, wraps mod 2^32
//   next                        : selected next PC
//   next_bad                    : next is misaligned or outside the ROM
module fetch_ctrl_pc_next_sel
    import fetch_ctrl_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next,
    output logic        next_bad
);

    localparam logic [31:0] LIMIT = 32'(INSTR_BYTES * MEM_WORDS);

    assign pc_plus4 = pc + 32'(INSTR_BYTES);

    always_comb begin
        next = pc_plus4;
        if (jump) begin
            next = jump_target;
        end else if (branch_taken) begin
            next = branch_target;
        end
    end

    // Falling off the last word is out of range rather than a wrap to 0.
    assign next_bad = (next[1:0] != 2'b00) || (next >= LIMIT);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - program counter and fetch sequencer for the monocycle core
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fetch_ctrl_if.master (controls, ROM port, qualified instruction, status)
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input logic          clock,
    input logic          reset,
    fetch_ctrl_if.master bus
);

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] fault_addr, fault_addr_nx;
    logic [31:0] retired, retired_nx;
    logic [31:0] pc_plus4;
    logic [31:0] next;
    logic        next_bad;
    logic        is_halt;

    fetch_ctrl_pc_next_sel #(
        .MEM_WORDS(MEM_WORDS)
    ) u_next_sel (
        .pc           (pc),
        .jump         (bus.jump),
        .jump_target  (bus.jump_target),
        .branch_taken (bus.branch_taken),
        .branch_target(bus.branch_target),
        .pc_plus4     (pc_plus4),
        .next         (next),
        .next_bad     (next_bad)
    );

    assign is_halt = (bus.i_data == HALT_WORD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            fault_addr <= 32'h0;
            retired    <= 32'h0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            fault_addr <= fault_addr_nx;
            retired    <= retired_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        fault_addr_nx = fault_addr;
        retired_nx    = retired;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                // A stalled cycle drops any redirect; the requester re-presents it.
                if (!bus.stall) begin
                    if (is_halt) begin
                        state_nx = ST_HALT;
                    end else if (next_bad) begin
                        state_nx      = ST_FAULT;
                        fault_addr_nx = next;
                    end else begin
                        pc_nx = next;
                        if (retired != 32'hFFFF_FFFF) begin
                            retired_nx = retired + 32'd1;
                        end
                    end
                end
            end
            ST_HALT: begin
                // Restart keeps the retired count running across programs.
                if (bus.start) begin
                    state_nx = ST_RUN;
                    pc_nx    = RESET_PC;
                end
            end
            ST_FAULT: begin
                state_nx = ST_FAULT;
            end
            default: begin
                state_nx = state;
            end
        endcase
    end

    assign bus.i_addr      = pc;
    assign bus.pc          = pc;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.instr_valid = (state == ST_RUN) && !bus.stall && !is_halt;
    assign bus.instr       = bus.instr_valid ? bus.i_data : 32'h0;
    assign bus.halted      = (state == ST_HALT);
    assign bus.fault       = (state == ST_FAULT);
    assign bus.fault_addr  = fault_addr;
    assign bus.retired     = retired;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a behavioural model
module tb_fetch_ctrl;

    localparam logic [31:0] HALT = 32'h0000_000C;
    localparam int          WORDS = 64;

    typedef enum int {M_IDLE, M_RUN, M_HALT, M_FAULT} mstate_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem [0:WORDS-1];
    int          total = 0;
    int          bad = 0;

    mstate_t     m_state;
    logic [31:0] m_pc;
    logic [31:0] m_faddr;
    logic [31:0] m_ret;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .MEM_WORDS(WORDS),
        .RESET_PC (32'h0),
        .HALT_WORD(HALT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    assign bus.i_data = (bus.i_addr < 32'd256) ? mem[bus.i_addr[7:2]] : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a < 32'd256) ? mem[a / 4] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] model_target();
        if (bus.jump) return bus.jump_target;
        if (bus.branch_taken) return bus.branch_target;
        return m_pc + 32'd4;
    endfunction

    function automatic logic target_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 * WORDS));
    endfunction

    // Reference model: architectural state updated from the rules directly.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state <= M_IDLE;
            m_pc    <= 32'h0;
            m_faddr <= 32'h0;
            m_ret   <= 32'h0;
        end else begin
            case (m_state)
                M_IDLE:  if (bus.start) m_state <= M_RUN;
                M_RUN: begin
                    if (!bus.stall) begin
                        if (rom_word(m_pc) == HALT) begin
                            m_state <= M_HALT;
                        end else if (target_bad(model_target())) begin
                            m_state <= M_FAULT;
                            m_faddr <= model_target();
                        end else begin
                            m_pc  <= model_target();
                            m_ret <= (m_ret == 32'hFFFF_FFFF) ? m_ret : m_ret + 32'd1;
                        end
                    end
                end
                M_HALT: begin
                    if (bus.start) begin
                        m_state <= M_RUN;
                        m_pc    <= 32'h0;
                    end
                end
                default: m_state <= m_state;
            endcase
        end
    end

    // Every-cycle comparison, on the falling edge away from state updates.
    always @(negedge clock) begin : cmp
        logic        ev;
        logic [31:0] w;
        w  = rom_word(m_pc);
        ev = (m_state == M_RUN) && !bus.stall && (w != HALT);
        check("pc", bus.pc, m_pc);
        check("i_addr", bus.i_addr, m_pc);
        check("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        check("instr_valid", 32'(bus.instr_valid), 32'(ev));
        check("instr", bus.instr, ev ? w : 32'h0);
        check("halted", 32'(bus.halted), 32'(m_state == M_HALT));
        check("fault", 32'(bus.fault), 32'(m_state == M_FAULT));
        check("fault_addr", bus.fault_addr, m_faddr);
        check("retired", bus.retired, m_ret);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.stall = 0; bus.jump = 0; bus.branch_taken = 0;
        bus.jump_target = 0; bus.branch_target = 0;
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
        mem[4] = HALT;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("reset_pc", bus.pc, 32'h0);
        check("reset_valid", 32'(bus.instr_valid), 32'h0);
        check("reset_retired", bus.retired, 32'h0);

        // Four NOPs then the halt sentinel at 0x10
        pulse_start();
        repeat (6) tick();
        check("t1_halted", 32'(bus.halted), 32'h1);
        check("t1_pc", bus.pc, 32'h10);
        check("t1_retired", bus.retired, 32'd4);

        // Restart from HALT keeps the retired count
        pulse_start();
        check("t5_pc", bus.pc, 32'h0);
        check("t5_halted", 32'(bus.halted), 32'h0);
        check("t5_retired", bus.retired, 32'd4);
        repeat (2) tick();
        check("t2_pc_pre", bus.pc, 32'h8);

        // Jump beats branch
        bus.jump = 1; bus.jump_target = 32'h20;
        bus.branch_taken = 1; bus.branch_target = 32'h30;
        tick();
        bus.jump = 0; bus.branch_taken = 0;
        check("t2_pc", bus.pc, 32'h20);
        check("t2_retired", bus.retired, 32'd7);

        // Stall holds everything, then the held branch lands
        bus.jump = 1; bus.jump_target = 32'h0C;
        tick();
        bus.jump = 0;
        bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h40;
        repeat (3) tick();
        check("t3_pc_stall", bus.pc, 32'h0C);
        check("t3_valid_stall", 32'(bus.instr_valid), 32'h0);
        check("t3_retired_stall", bus.retired, 32'd8);
        bus.stall = 0;
        tick();
        bus.branch_taken = 0;
        check("t3_pc", bus.pc, 32'h40);
        check("t3_retired", bus.retired, 32'd9);

        // Misaligned branch target faults; start ignored; reset recovers
        bus.branch_taken = 1; bus.branch_target = 32'h102;
        tick();
        bus.branch_taken = 0;
        check("t4a_fault", 32'(bus.fault), 32'h1);
        check("t4a_faddr", bus.fault_addr, 32'h102);
        check("t4a_pc", bus.pc, 32'h40);
        pulse_start();
        check("t4a_sticky", 32'(bus.fault), 32'h1);
        pulse_reset();
        check("t4a_reset_pc", bus.pc, 32'h0);
        check("t4a_reset_fault", 32'(bus.fault), 32'h0);

        // Sequential fetch past the last word faults at 0x100
        pulse_start();
        bus.jump = 1; bus.jump_target = 32'hFC;
        tick();
        bus.jump = 0;
        check("t4b_pc_pre", bus.pc, 32'hFC);
        tick();
        check("t4b_fault", 32'(bus.fault), 32'h1);
        check("t4b_faddr", bus.fault_addr, 32'h100);
        check("t4b_pc", bus.pc, 32'hFC);
        pulse_start();
        check("t4b_sticky", 32'(bus.fault), 32'h1);
        pulse_reset();

        // Asynchronous reset mid-cycle at pc=0x14
        pulse_start();
        bus.jump = 1; bus.jump_target = 32'h14;
        tick();
        bus.jump = 0;
        check("t6_pc_pre", bus.pc, 32'h14);
        #1 reset = 1'b1;
        #1;
        check("t6_async_pc", bus.pc, 32'h0);
        check("t6_async_valid", 32'(bus.instr_valid), 32'h0);
        check("t6_async_retired", bus.retired, 32'h0);
        #1 reset = 1'b0;
        repeat (3) tick();
        check("t6_idle_pc", bus.pc, 32'h0);
        check("t6_idle_valid", 32'(bus.instr_valid), 32'h0);

        // Randomized traffic against the model
        pulse_reset();
        for (int i = 0; i < WORDS; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? HALT : ($urandom | 32'h100);
        for (int n = 0; n < 3000; n++) begin
            if ((m_state == M_FAULT && $urandom_range(0, 19) == 0) || $urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                bus.start        = ($urandom_range(0, 9) == 0);
                bus.stall        = ($urandom_range(0, 3) == 0);
                bus.jump         = ($urandom_range(0, 7) == 0);
                bus.branch_taken = ($urandom_range(0, 4) == 0);
                bus.jump_target   = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 300))
                                                               : 32'($urandom_range(0, WORDS - 1) * 4);
                bus.branch_target = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 300))
                                                               : 32'($urandom_range(0, WORDS - 1) * 4);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
